pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer replacing the fixed 32-bit PC register in the single-cycle core's writeback stage. It holds the PC, advances it by one instruction word per cycle, and supports a stall hold, a taken-branch/jump redirect, and call/return through an internal circular return-address stack (RAS). Sticky error flags report RAS overflow, RAS underflow and misaligned redirect targets. The fetch stage reads `fetch_addr`; the execute stage drives the control inputs.

## Interface
- `XLEN`, 32: PC width in bits (≥ 8).
- `RESET_PC`, 0: PC value loaded on reset; must be word aligned.
- `RAS_DEPTH`, 4: return-address stack entries (power of two, ≥ 2).
- `IMEM_AW`, 8: width of `fetch_addr`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstd`  in  1  reset; asynchronous, active-low.
- `stall`  in  1  hold PC and RAS this cycle.
- `redirect`  in  1  taken branch/jump: load `target`.
- `call`  in  1  push `pc+4`, load `target`.
- `ret`  in  1  pop RAS top into PC.
- `target`  in  XLEN  redirect/call target; also the fallback for `ret` on an empty RAS.
- `flag_clr`  in  1  clear all sticky flags.
- `pc`  out  XLEN  current PC (registered).
- `next_pc`  out  XLEN  value PC takes at the next edge (combinational).
- `fetch_addr`  out  IMEM_AW  `pc[IMEM_AW-1:0]`.
- `ras_count`  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- `ras_ovf`  out  1  sticky: push while full.
- `ras_unf`  out  1  sticky: `ret` while empty.
- `misalign`  out  1  sticky: a loaded `target` had `target[1:0] != 0`.

## Operation
- Next-PC selection, fixed priority: `stall` > `ret` > `call` > `redirect` > sequential (`pc+4`, mod 2^XLEN, wraps silently).
- `stall`: PC, RAS, count and flags unchanged (except `flag_clr`, which still acts). Other commands in the same cycle are discarded.
- `redirect`: PC ← `{target[XLEN-1:2], 2'b00}`; `misalign` set if `target[1:0] != 0`.
- `call`: the value pushed is `pc+4` of the current PC; PC ← aligned `target`, with the same misalign rule. Not full: write at top pointer, pointer+1, count+1. Full: circular overwrite of the oldest entry, pointer+1, count stays `RAS_DEPTH`, `ras_ovf` set.
- `ret`, count > 0: PC ← entry at pointer−1, pointer−1, count−1. Count = 0: PC ← aligned `target`, stack untouched, `ras_unf` set, misalign rule applies.
- Pointer arithmetic is modulo `RAS_DEPTH`.
- Lower-priority commands asserted with a higher one are ignored entirely; e.g. `call`+`redirect` performs the call only.
- `flag_clr` clears the flags at the edge. A flag set in the same cycle wins: set has priority over clear.

## Timing
- Async reset (`rstd`=0) immediately forces `pc`=`RESET_PC`, `ras_count`=0, pointer=0, all RAS entries 0, and all flags 0. Outputs hold these values while reset is asserted.
- Reset deassertion is synchronous in effect: the first rising edge after `rstd` goes high loads `next_pc`. `fetch_addr` equals `RESET_PC[IMEM_AW-1:0]` in the first cycle.
- Reset asserted mid-call/ret aborts the operation; no partial RAS update survives.
- One-cycle latency from control input to `pc`. `next_pc` is valid in the same cycle, purely combinational from `pc`, the RAS top and the inputs.
- No handshakes: inputs are sampled every edge and must be stable before it.
- A `ret` in the cycle immediately after a `call` returns that call's `pc+4`, with no forwarding hazard because the push completes at the edge.

## Test plan
- Reset and sequential run: `RESET_PC`=0x100, release `rstd`, 3 idle cycles → `pc` goes 0x100, 0x104, 0x108, 0x10C; `fetch_addr`=0x0C. Assert `rstd`=0 between edges → `pc`=0x100 immediately.
- Call/return nesting: at `pc`=0x10, `call` with `target`=0x40; at 0x40, `call` with 0x80; then `ret`, `ret` → `pc` sequence is 0x40, 0x80, 0x44, 0x14, and `ras_count` goes 1, 2, 1, 0.
- Overflow: `RAS_DEPTH`=4, five calls from PCs 0x0, 0x100, 0x200, 0x300, 0x400 → `ras_ovf`=1, `ras_count`=4. Four rets return 0x404, 0x304, 0x204, 0x104. A fifth `ret` with `target`=0x900 → `pc`=0x900, `ras_unf`=1.
- Priority and stall: `stall`+`ret`+`redirect` → `pc` and `ras_count` unchanged. `call`+`redirect` with `target`=0x60 → `pc`=0x60, one push.
- Misalign and flags: `redirect` with `target`=0x33 → `pc`=0x30, `misalign`=1. A later `flag_clr` → all flags 0. `flag_clr` in the same cycle as a misaligned redirect → `misalign` stays 1.
- Wrap: `pc`=0xFFFFFFFC, idle edge → `pc`=0x0, with no flag set.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Control and status bundle between the execute/fetch stages and the PC sequencer.
interface pc_sequencer_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned IMEM_AW   = 8,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    logic               stall;
    logic               redirect;
    logic               call;
    logic               ret;
    logic [XLEN-1:0]    target;
    logic               flag_clr;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    next_pc;
    logic [IMEM_AW-1:0] fetch_addr;
    logic [CNT_W-1:0]   ras_count;
    logic               ras_ovf;
    logic               ras_unf;
    logic               misalign;

    modport master (
        output stall, redirect, call, ret, target, flag_clr,
        input  pc, next_pc, fetch_addr, ras_count, ras_ovf, ras_unf, misalign
    );

    modport slave (
        input  stall, redirect, call, ret, target, flag_clr,
        output pc, next_pc, fetch_addr, ras_count, ras_ovf, ras_unf, misalign
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with stall, redirect and call/return through a circular
// return-address stack; sticky flags report RAS overflow/underflow and misaligned targets.
module pc_sequencer #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter int unsigned     IMEM_AW   = 8
) (
    input logic           clk,
    input logic           rstd,
    pc_sequencer_if.slave sq
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [XLEN-1:0]  WORD    = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q, unf_q, mis_q;

    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  aligned_tgt;
    logic [XLEN-1:0]  ras_top;
    logic [XLEN-1:0]  npc;
    logic             tgt_mis;
    logic             push, pop;
    logic             ovf_set, unf_set, mis_set;

    assign pc_plus4    = pc_q + WORD;
    assign aligned_tgt = {sq.target[XLEN-1:2], 2'b00};
    assign tgt_mis     = |sq.target[1:0];
    assign ras_top     = ras_q[ptr_q - PTR_W'(1)];

    // Next-PC select, fixed priority stall > ret > call > redirect > sequential
    always_comb begin
        npc     = pc_plus4;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        mis_set = 1'b0;
        if (sq.stall) begin
            npc = pc_q;
        end else if (sq.ret) begin
            if (count_q != '0) begin
                npc = ras_top;
                pop = 1'b1;
            end else begin
                npc     = aligned_tgt;
                unf_set = 1'b1;
                mis_set = tgt_mis;
            end
        end else if (sq.call) begin
            npc     = aligned_tgt;
            push    = 1'b1;
            ovf_set = (count_q == CNT_MAX);
            mis_set = tgt_mis;
        end else if (sq.redirect) begin
            npc     = aligned_tgt;
            mis_set = tgt_mis;
        end
    end

    // PC and return-address stack; a full push overwrites the oldest entry
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            pc_q    <= RESET_PC;
            ptr_q   <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q <= npc;
            if (push) begin
                ras_q[ptr_q] <= pc_plus4;
                ptr_q        <= ptr_q + PTR_W'(1);
                if (count_q != CNT_MAX) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end else if (pop) begin
                ptr_q   <= ptr_q - PTR_W'(1);
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Sticky flags: a set in the same cycle beats flag_clr
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            mis_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~sq.flag_clr);
            unf_q <= unf_set | (unf_q & ~sq.flag_clr);
            mis_q <= mis_set | (mis_q & ~sq.flag_clr);
        end
    end

    assign sq.pc         = pc_q;
    assign sq.next_pc    = npc;
    assign sq.fetch_addr = pc_q[IMEM_AW-1:0];
    assign sq.ras_count  = count_q;
    assign sq.ras_ovf    = ovf_q;
    assign sq.ras_unf    = unf_q;
    assign sq.misalign   = mis_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random commands
// compared against a queue-based return-stack model.
module tb_pc_sequencer;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned IMEM_AW   = 8;
    localparam int unsigned DEPTH     = 4;
    localparam logic [31:0] RST_PC    = 32'h100;

    logic clk;
    logic rstd;

    pc_sequencer_if #(.XLEN(XLEN), .IMEM_AW(IMEM_AW), .RAS_DEPTH(DEPTH)) sq ();

    pc_sequencer #(
        .XLEN(XLEN), .RESET_PC(RST_PC), .RAS_DEPTH(DEPTH), .IMEM_AW(IMEM_AW)
    ) dut (
        .clk  (clk),
        .rstd (rstd),
        .sq   (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: the stack is a queue, newest at the back
    logic [31:0] m_pc;
    logic [31:0] m_ras [$];
    logic        m_ovf, m_unf, m_mis;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_mis = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".pc"},    sq.pc,         m_pc);
        check({tag, ".fetch"}, sq.fetch_addr, m_pc[7:0]);
        check({tag, ".count"}, sq.ras_count,  64'(m_ras.size()));
        check({tag, ".flags"}, {sq.ras_ovf, sq.ras_unf, sq.misalign}, {m_ovf, m_unf, m_mis});
    endtask

    // Called just after a falling edge; returns just after the next falling edge
    task automatic step(input logic s, input logic r, input logic c, input logic rt,
                        input logic [31:0] t, input logic fc);
        logic [31:0] exp_npc;
        logic [31:0] al;
        logic        so, su, sm;
        sq.stall    = s;
        sq.redirect = r;
        sq.call     = c;
        sq.ret      = rt;
        sq.target   = t;
        sq.flag_clr = fc;
        al = t & 32'hFFFF_FFFC;
        so = 1'b0; su = 1'b0; sm = 1'b0;
        exp_npc = m_pc + 32'd4;
        if (s) begin
            exp_npc = m_pc;
        end else if (rt) begin
            if (m_ras.size() > 0) begin
                exp_npc = m_ras.pop_back();
            end else begin
                exp_npc = al;
                su = 1'b1;
                sm = (t[1:0] != 2'b00);
            end
        end else if (c) begin
            if (m_ras.size() == DEPTH) so = 1'b1;
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            exp_npc = al;
            sm = (t[1:0] != 2'b00);
        end else if (r) begin
            exp_npc = al;
            sm = (t[1:0] != 2'b00);
        end
        #1;
        check("next_pc", sq.next_pc, exp_npc);
        @(posedge clk);
        #1;
        m_pc  = exp_npc;
        m_ovf = so | (m_ovf & ~fc);
        m_unf = su | (m_unf & ~fc);
        m_mis = sm | (m_mis & ~fc);
        check_state("step");
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic jump(input logic [31:0] t);
        step(1'b0, 1'b1, 1'b0, 1'b0, t, 1'b0);
    endtask

    task automatic do_call(input logic [31:0] t);
        step(1'b0, 1'b0, 1'b1, 1'b0, t, 1'b0);
    endtask

    task automatic do_ret(input logic [31:0] t);
        step(1'b0, 1'b0, 1'b0, 1'b1, t, 1'b0);
    endtask

    task automatic clear_flags();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        logic        rs, rr, rc, rrt, rfc;
        logic [31:0] rt_tgt;

        rstd        = 1'b0;
        sq.stall    = 1'b0;
        sq.redirect = 1'b0;
        sq.call     = 1'b0;
        sq.ret      = 1'b0;
        sq.target   = '0;
        sq.flag_clr = 1'b0;
        model_reset();

        // Reset values held while rstd is low
        @(negedge clk);
        @(negedge clk);
        check("rst_pc",    sq.pc, 32'h100);
        check("rst_fetch", sq.fetch_addr, 8'h00);
        check("rst_count", sq.ras_count, 0);
        check("rst_flags", {sq.ras_ovf, sq.ras_unf, sq.misalign}, 3'b000);

        // Release reset, sequential run
        rstd = 1'b1;
        #1;
        check_state("first");
        idle(); idle(); idle();
        check("seq_pc",    sq.pc, 32'h10C);
        check("seq_fetch", sq.fetch_addr, 8'h0C);

        // Asynchronous reset between edges takes effect immediately
        #2;
        rstd = 1'b0;
        #1;
        check("async_rst_pc", sq.pc, 32'h100);
        @(negedge clk);
        rstd = 1'b1;
        model_reset();

        // Reset during a call aborts it with no RAS update
        sq.call = 1'b1; sq.target = 32'h500;
        #2;
        rstd = 1'b0;
        #1;
        check("abort_pc",    sq.pc, 32'h100);
        check("abort_count", sq.ras_count, 0);
        @(negedge clk);
        sq.call = 1'b0;
        rstd = 1'b1;
        model_reset();
        check_state("abort");

        // Call/return nesting
        jump(32'h10);
        do_call(32'h40);
        check("nest_pc1", sq.pc, 32'h40);  check("nest_cnt1", sq.ras_count, 1);
        do_call(32'h80);
        check("nest_pc2", sq.pc, 32'h80);  check("nest_cnt2", sq.ras_count, 2);
        do_ret(32'h0);
        check("nest_pc3", sq.pc, 32'h44);  check("nest_cnt3", sq.ras_count, 1);
        do_ret(32'h0);
        check("nest_pc4", sq.pc, 32'h14);  check("nest_cnt4", sq.ras_count, 0);

        // Overflow: five calls into a four-entry stack
        jump(32'h0);
        do_call(32'h100); do_call(32'h200); do_call(32'h300); do_call(32'h400); do_call(32'h500);
        check("ovf_flag",  sq.ras_ovf, 1'b1);
        check("ovf_count", sq.ras_count, 4);
        do_ret(32'h0); check("ovf_ret1", sq.pc, 32'h404);
        do_ret(32'h0); check("ovf_ret2", sq.pc, 32'h304);
        do_ret(32'h0); check("ovf_ret3", sq.pc, 32'h204);
        do_ret(32'h0); check("ovf_ret4", sq.pc, 32'h104);
        do_ret(32'h900);
        check("unf_pc",   sq.pc, 32'h900);
        check("unf_flag", sq.ras_unf, 1'b1);

        // Priority: stall swallows everything; call beats redirect
        clear_flags();
        do_call(32'h200);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h700, 1'b0);
        check("stall_pc",  sq.pc, 32'h200);
        check("stall_cnt", sq.ras_count, 1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h60, 1'b0);
        check("callredir_pc",  sq.pc, 32'h60);
        check("callredir_cnt", sq.ras_count, 2);
        do_ret(32'h0);
        check("callredir_ret", sq.pc, 32'h204);

        // Misalign and flag clear priority
        jump(32'h33);
        check("mis_pc",   sq.pc, 32'h30);
        check("mis_flag", sq.misalign, 1'b1);
        clear_flags();
        check("clr_flags", {sq.ras_ovf, sq.ras_unf, sq.misalign}, 3'b000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h33, 1'b1);
        check("set_beats_clr", sq.misalign, 1'b1);

        // PC wrap
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1);
        idle();
        check("wrap_pc",    sq.pc, 32'h0);
        check("wrap_flags", {sq.ras_ovf, sq.ras_unf, sq.misalign}, 3'b000);

        // Random commands against the model
        for (int i = 0; i < 400; i++) begin
            rs     = ($urandom_range(0, 7) == 0);
            rr     = ($urandom_range(0, 3) == 0);
            rc     = ($urandom_range(0, 3) == 0);
            rrt    = ($urandom_range(0, 3) == 0);
            rfc    = ($urandom_range(0, 7) == 0);
            rt_tgt = $urandom();
            if ($urandom_range(0, 9) != 0) rt_tgt[1:0] = 2'b00;
            step(rs, rr, rc, rrt, rt_tgt, rfc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
